// File: rtl/control_unit_if.sv
// Opcode/flag inputs and decoded control outputs of the MIPS main decoder.
// The master side drives opcode and flags; the slave side is the decoder.
interface control_unit_if;
   logic [5:0] opcode;
   logic       eq;
   logic       les;
   logic       upper;
   logic       RegDst;
   logic       Branch;
   logic       Bne;
   logic       MemRead;
   logic       MemtoReg;
   logic [1:0] ALUop;
   logic       MemWrite;
   logic       ALUSrc;
   logic [1:0] RegWrite;
   logic [1:0] sRs;
   logic [1:0] sRdD;
   logic       Jump;
   logic       Jal;

   modport master (
      output opcode, eq, les, upper,
      input  RegDst, Branch, Bne, MemRead, MemtoReg, ALUop, MemWrite,
             ALUSrc, RegWrite, sRs, sRdD, Jump, Jal
   );

   modport slave (
      input  opcode, eq, les, upper,
      output RegDst, Branch, Bne, MemRead, MemtoReg, ALUop, MemWrite,
             ALUSrc, RegWrite, sRs, sRdD, Jump, Jal
   );
endinterface

// File: rtl/control_unit.sv
// Registered main decoder for the single-issue MIPS datapath (one cycle latency).
// Define CU_IMM_OPS_EN to add the addi/slti immediate opcodes.
module control_unit (
   input logic           clk,
   input logic           reset,
   control_unit_if.slave bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
`ifdef CU_IMM_OPS_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
`endif

   logic       regDstD, branchD, bneD, memReadD, memtoRegD, memWriteD;
   logic       aluSrcD, jumpD, jalD;
   logic [1:0] aluOpD, regWriteD, sRsD, sRdDD;

   // Flags are only consulted inside the R-type arm so unknowns on them
   // cannot reach the outputs for any other opcode.
   always_comb begin
      regDstD   = 1'b0;
      branchD   = 1'b0;
      bneD      = 1'b0;
      memReadD  = 1'b0;
      memtoRegD = 1'b0;
      memWriteD = 1'b0;
      aluSrcD   = 1'b0;
      jumpD     = 1'b0;
      jalD      = 1'b0;
      aluOpD    = 2'b00;
      regWriteD = 2'b00;
      sRsD      = 2'b00;
      sRdDD     = 2'b00;
      case (bus.opcode)
         OP_RTYPE: begin
            regDstD   = 1'b1;
            regWriteD = 2'b01;
            aluOpD    = 2'b10;
            if (bus.eq) begin
               sRsD  = 2'b01;
               sRdDD = 2'b01;
            end else if (bus.les) begin
               sRsD  = 2'b10;
               sRdDD = 2'b10;
            end else if (bus.upper) begin
               sRsD  = 2'b11;
               sRdDD = 2'b11;
            end
         end
         OP_LW: begin
            aluSrcD   = 1'b1;
            memReadD  = 1'b1;
            memtoRegD = 1'b1;
            regWriteD = 2'b01;
         end
         OP_SW: begin
            aluSrcD   = 1'b1;
            memWriteD = 1'b1;
         end
         OP_BEQ: begin
            branchD = 1'b1;
            aluOpD  = 2'b01;
         end
         OP_BNE: begin
            bneD   = 1'b1;
            aluOpD = 2'b01;
         end
         OP_J: begin
            jumpD = 1'b1;
         end
         OP_JAL: begin
            jumpD     = 1'b1;
            jalD      = 1'b1;
            regWriteD = 2'b10;
         end
`ifdef CU_IMM_OPS_EN
         OP_ADDI: begin
            aluSrcD   = 1'b1;
            regWriteD = 2'b01;
         end
         OP_SLTI: begin
            aluSrcD   = 1'b1;
            regWriteD = 2'b01;
            aluOpD    = 2'b11;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.RegDst   <= 1'b0;
         bus.Branch   <= 1'b0;
         bus.Bne      <= 1'b0;
         bus.MemRead  <= 1'b0;
         bus.MemtoReg <= 1'b0;
         bus.ALUop    <= 2'b00;
         bus.MemWrite <= 1'b0;
         bus.ALUSrc   <= 1'b0;
         bus.RegWrite <= 2'b00;
         bus.sRs      <= 2'b00;
         bus.sRdD     <= 2'b00;
         bus.Jump     <= 1'b0;
         bus.Jal      <= 1'b0;
      end else begin
         bus.RegDst   <= regDstD;
         bus.Branch   <= branchD;
         bus.Bne      <= bneD;
         bus.MemRead  <= memReadD;
         bus.MemtoReg <= memtoRegD;
         bus.ALUop    <= aluOpD;
         bus.MemWrite <= memWriteD;
         bus.ALUSrc   <= aluSrcD;
         bus.RegWrite <= regWriteD;
         bus.sRs      <= sRsD;
         bus.sRdD     <= sRdDD;
         bus.Jump     <= jumpD;
         bus.Jal      <= jalD;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expected values are hand-derived.
// Expectations for opcode 001010 follow CU_IMM_OPS_EN when it is defined.
module tb_control_unit;

   logic clk = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;

   control_unit_if bus ();

   control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // {RegDst,Branch,Bne,MemRead,MemtoReg,ALUop,MemWrite,ALUSrc,RegWrite,sRs,sRdD,Jump,Jal}
   logic [16:0] obsVec;
   assign obsVec = {bus.RegDst, bus.Branch, bus.Bne, bus.MemRead, bus.MemtoReg,
                    bus.ALUop, bus.MemWrite, bus.ALUSrc, bus.RegWrite,
                    bus.sRs, bus.sRdD, bus.Jump, bus.Jal};

   function automatic logic [16:0] ev(
      input logic regDst, input logic branch, input logic bne,
      input logic memRead, input logic memtoReg, input logic [1:0] aluOp,
      input logic memWrite, input logic aluSrc, input logic [1:0] regWrite,
      input logic [1:0] sRs, input logic [1:0] sRdD, input logic jump,
      input logic jal);
      return {regDst, branch, bne, memRead, memtoReg, aluOp, memWrite,
              aluSrc, regWrite, sRs, sRdD, jump, jal};
   endfunction

   task automatic check(input string tag, input logic [16:0] expVec);
      compared++;
      assert (obsVec === expVec) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, obsVec, expVec);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic e, input logic l,
                        input logic u);
      bus.opcode = op;
      bus.eq     = e;
      bus.les    = l;
      bus.upper  = u;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [16:0] ZERO = 17'd0;
   logic [16:0] lwVec, rVec;

   initial begin
      lwVec = ev(0,0,0,1,1,2'b00,0,1,2'b01,2'b00,2'b00,0,0);

      // reset held while lw is presented and clocked
      reset = 1'b1;
      drive(6'b100011, 1'bx, 1'bx, 1'bx);
      #2;
      check("reset_async_init", ZERO);
      step();
      step();
      check("reset_hold_lw", ZERO);

      // release between edges; first edge decodes lw
      #3;
      reset = 1'b0;
      step();
      check("lw", lwVec);

      // sw, beq, bne back to back with flags unknown
      drive(6'b101011, 1'bx, 1'bx, 1'bx);
      step();
      check("sw", ev(0,0,0,0,0,2'b00,1,1,2'b00,2'b00,2'b00,0,0));
      drive(6'b000100, 1'bx, 1'bx, 1'bx);
      step();
      check("beq", ev(0,1,0,0,0,2'b01,0,0,2'b00,2'b00,2'b00,0,0));
      drive(6'b000101, 1'bx, 1'bx, 1'bx);
      step();
      check("bne", ev(0,0,1,0,0,2'b01,0,0,2'b00,2'b00,2'b00,0,0));

      // jumps, with flags set high to show they are ignored
      drive(6'b000010, 1'b1, 1'b1, 1'b1);
      step();
      check("j", ev(0,0,0,0,0,2'b00,0,0,2'b00,2'b00,2'b00,1,0));
      drive(6'b000011, 1'b1, 1'b0, 1'b0);
      step();
      check("jal", ev(0,0,0,0,0,2'b00,0,0,2'b10,2'b00,2'b00,1,1));

      // R-type flag priority eq > les > upper
      drive(6'b000000, 1'b1, 1'b0, 1'b0);
      step();
      rVec = ev(1,0,0,0,0,2'b10,0,0,2'b01,2'b01,2'b01,0,0);
      check("rtype_eq", rVec);
      drive(6'b000000, 1'b0, 1'b1, 1'b0);
      step();
      rVec = ev(1,0,0,0,0,2'b10,0,0,2'b01,2'b10,2'b10,0,0);
      check("rtype_les", rVec);
      drive(6'b000000, 1'b0, 1'b0, 1'b1);
      step();
      rVec = ev(1,0,0,0,0,2'b10,0,0,2'b01,2'b11,2'b11,0,0);
      check("rtype_upper", rVec);
      drive(6'b000000, 1'b0, 1'b0, 1'b0);
      step();
      rVec = ev(1,0,0,0,0,2'b10,0,0,2'b01,2'b00,2'b00,0,0);
      check("rtype_none", rVec);
      drive(6'b000000, 1'b1, 1'b1, 1'b1);
      step();
      rVec = ev(1,0,0,0,0,2'b10,0,0,2'b01,2'b01,2'b01,0,0);
      check("rtype_all", rVec);
      drive(6'b000000, 1'b0, 1'b1, 1'b1);
      step();
      rVec = ev(1,0,0,0,0,2'b10,0,0,2'b01,2'b10,2'b10,0,0);
      check("rtype_les_upper", rVec);

      // unsupported opcode
      drive(6'b111111, 1'b1, 1'b1, 1'b1);
      step();
      check("nop_111111", ZERO);

      // immediate opcodes
      drive(6'b001010, 1'b0, 1'b0, 1'b0);
      step();
`ifdef CU_IMM_OPS_EN
      check("slti", ev(0,0,0,0,0,2'b11,0,1,2'b01,2'b00,2'b00,0,0));
`else
      check("slti_off", ZERO);
`endif
      drive(6'b001000, 1'b0, 1'b0, 1'b0);
      step();
`ifdef CU_IMM_OPS_EN
      check("addi", ev(0,0,0,0,0,2'b00,0,1,2'b01,2'b00,2'b00,0,0));
`else
      check("addi_off", ZERO);
`endif

      // async reset while lw outputs are valid
      drive(6'b100011, 1'b0, 1'b0, 1'b0);
      step();
      check("lw_before_reset", lwVec);
      #1;
      reset = 1'b1;
      #1;
      check("reset_async_mid", ZERO);
      drive(6'b000011, 1'b0, 1'b0, 1'b0);
      step();
      check("reset_hold_jal", ZERO);
      #3;
      reset = 1'b0;
      step();
      check("jal_after_reset", ev(0,0,0,0,0,2'b00,0,0,2'b10,2'b00,2'b00,1,1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
